// File: rtl/alu_mdu_if.sv
// Request/response bus of the iterative ALU/MDU.
// The master drives the operation and operands and takes the result.
// The slave (the ALU) accepts requests and presents registered results.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] ALU_in_X;
    logic [WIDTH-1:0] ALU_in_Y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_out_S;
    logic             ZR;
    logic             NG;

    modport master (
        output in_valid, operation, ALU_in_X, ALU_in_Y, out_ready,
        input  in_ready, out_valid, ALU_out_S, ZR, NG
    );

    modport slave (
        input  in_valid, operation, ALU_in_X, ALU_in_Y, out_ready,
        output in_ready, out_valid, ALU_out_S, ZR, NG
    );
endinterface

// File: rtl/alu_mdu.sv
// ALU with an iterative multiply/divide unit.
// Single-cycle ops are computed straight from the bus at the accept edge.
// MUL/MULHU use a shift-add multiplier and DIVU/REMU a restoring divider.
// Both iterate one bit per cycle in a shared 2*WIDTH-bit accumulator.
// A divide by zero short-cuts to a fixed result in one cycle.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     reset,
    alu_mdu_if.slave bus
);

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0011,
        OP_SLL   = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_SLTU  = 4'b1000,
        OP_SRA   = 4'b1001,
        OP_MUL   = 4'b1010,
        OP_MULHU = 4'b1011,
        OP_NOR   = 4'b1100,
        OP_DIVU  = 4'b1101,
        OP_REMU  = 4'b1110,
        OP_RSVD  = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e             state;
    op_e                op_q;
    logic [WIDTH-1:0]   x_q;      // multiplicand for MUL*, divisor for DIV*
    logic [2*WIDTH-1:0] acc;      // {product high, multiplier} or {remainder, dividend/quotient}
    logic [SHW-1:0]     cnt;
    logic [WIDTH-1:0]   res_q;
    logic               zr_q;
    logic               ng_q;
    logic               out_valid_q;

    logic               accept;
    op_e                op_in;
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   single_res;
    logic               is_iter;
    logic [WIDTH:0]     mul_hi;
    logic [WIDTH:0]     div_part;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   iter_res;
    logic [WIDTH-1:0]   load_res;

    // A new request can be taken when idle, or when the held result leaves this cycle.
    assign bus.in_ready  = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.ALU_out_S = res_q;
    assign bus.ZR        = zr_q;
    assign bus.NG        = ng_q;

    // Single-cycle result and op classification straight from the request bus.
    always_comb begin
        // NOTE: default every output first so no path through the case infers a latch.
        op_in      = op_e'(bus.operation);
        sh         = bus.ALU_in_Y[SHW-1:0];
        single_res = bus.ALU_in_X & bus.ALU_in_Y;
        is_iter    = 1'b0;
        case (op_in)
            OP_OR:   single_res = bus.ALU_in_X | bus.ALU_in_Y;
            OP_ADD:  single_res = bus.ALU_in_X + bus.ALU_in_Y;
            OP_XOR:  single_res = bus.ALU_in_X ^ bus.ALU_in_Y;
            OP_SLL:  single_res = bus.ALU_in_X << sh;
            OP_SRL:  single_res = bus.ALU_in_X >> sh;
            OP_SUB:  single_res = bus.ALU_in_X - bus.ALU_in_Y;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(bus.ALU_in_X) < $signed(bus.ALU_in_Y)};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, bus.ALU_in_X < bus.ALU_in_Y};
            OP_SRA:  single_res = $unsigned($signed(bus.ALU_in_X) >>> sh);
            OP_NOR:  single_res = ~(bus.ALU_in_X | bus.ALU_in_Y);
            OP_DIVU: single_res = '1;            // only used for a zero divisor
            OP_REMU: single_res = bus.ALU_in_X;  // only used for a zero divisor
            default: single_res = bus.ALU_in_X & bus.ALU_in_Y;
        endcase
        case (op_in)
            OP_MUL, OP_MULHU: is_iter = 1'b1;
            OP_DIVU, OP_REMU: is_iter = (bus.ALU_in_Y != '0);
            default:          is_iter = 1'b0;
        endcase
    end

    // One multiply or divide step on the accumulator, and the result it yields on the last step.
    always_comb begin
        mul_hi   = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, x_q})
                          : {1'b0, acc[2*WIDTH-1:WIDTH]};
        div_part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge   = (div_part >= {1'b0, x_q});
        div_sub  = div_part[WIDTH-1:0] - x_q;
        acc_next = {mul_hi, acc[WIDTH-1:1]};
        if ((op_q == OP_DIVU) || (op_q == OP_REMU)) begin
            acc_next = div_ge ? {div_sub, acc[WIDTH-2:0], 1'b1}
                              : {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
        iter_res = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? acc_next[WIDTH-1:0]
                                                          : acc_next[2*WIDTH-1:WIDTH];
        load_res = (state == S_BUSY) ? iter_res : single_res;
    end

    // Control FSM, iteration datapath and registered result.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
        if (reset) begin
            // NOTE: the datapath registers are cleared too, so an aborted operation leaves nothing behind.
            state       <= S_IDLE;
            op_q        <= OP_AND;
            x_q         <= '0;
            acc         <= '0;
            cnt         <= '0;
            res_q       <= '0;
            zr_q        <= 1'b0;
            ng_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + SHW'(1);
                    if (cnt == SHW'(WIDTH - 1)) begin
                        state       <= S_DONE;
                        out_valid_q <= 1'b1;
                        res_q       <= load_res;
                        zr_q        <= (load_res == '0);
                        ng_q        <= load_res[WIDTH-1];
                    end
                end
                default: begin
                    if (accept) begin
                        op_q <= op_in;
                        if (is_iter) begin
                            state       <= S_BUSY;
                            out_valid_q <= 1'b0;
                            cnt         <= '0;
                            if ((op_in == OP_DIVU) || (op_in == OP_REMU)) begin
                                x_q <= bus.ALU_in_Y;
                                acc <= {{WIDTH{1'b0}}, bus.ALU_in_X};
                            end else begin
                                x_q <= bus.ALU_in_X;
                                acc <= {{WIDTH{1'b0}}, bus.ALU_in_Y};
                            end
                        end else begin
                            state       <= S_DONE;
                            out_valid_q <= 1'b1;
                            res_q       <= load_res;
                            zr_q        <= (load_res == '0);
                            ng_q        <= load_res[WIDTH-1];
                        end
                    end else if ((state == S_DONE) && bus.out_ready) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; legal values are powers of two, 8 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation and operands presented.
REQ-006 in_ready  output  1  block accepts the request this cycle.
REQ-007 operation  input  4  opcode, per REQ-012.
REQ-008 ALU_in_X, ALU_in_Y  input  WIDTH  operands X and Y.
REQ-009 out_valid  output  1  ALU_out_S, ZR and NG hold a valid result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 ALU_out_S  output  WIDTH  result; ZR  output  1  result==0; NG  output  1  result[WIDTH-1].

Function
REQ-012 Opcodes SHALL be:
- 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 SLL; 0101 SRL
- 0110 SUB; 0111 SLT (signed); 1000 SLTU; 1001 SRA; 1010 MUL (low WIDTH bits)
- 1011 MULHU (high WIDTH bits, unsigned); 1100 NOR; 1101 DIVU; 1110 REMU
- 1111 is reserved and SHALL execute as AND.
REQ-013 A request SHALL be accepted on a cycle where in_valid && in_ready are both high. The opcode and both operands SHALL be captured internally on acceptance.
REQ-014 ADD, SUB and MUL SHALL wrap modulo 2^WIDTH. Shift ops SHALL use only ALU_in_Y[SHW-1:0]. SLT and SLTU SHALL return 1 or 0, zero-extended to WIDTH.
REQ-015 FSM states:
- IDLE: in_ready=1.
- BUSY: iterative MUL/MULHU/DIVU/REMU in progress; in_ready=0.
- DONE: out_valid=1; in_ready=out_ready.
REQ-016 Transitions:
- IDLE + accept of a single-cycle op (or divide by zero) -> DONE.
- IDLE + accept of MUL/MULHU/DIVU/REMU with nonzero divisor -> BUSY.
- BUSY after exactly WIDTH iteration cycles -> DONE.
- DONE + out_ready without accept -> IDLE.
- DONE + out_ready with accept -> DONE or BUSY, as for IDLE.
REQ-017 Latency from the accept edge to out_valid high:
- single-cycle ops: 1 cycle.
- MUL, MULHU, DIVU, REMU: WIDTH+1 cycles.
REQ-018 Multiply SHALL be shift-add, one bit per cycle, into a 2*WIDTH-bit accumulator.
REQ-019 Divide SHALL be restoring, one quotient bit per cycle.
REQ-020 Divide by zero SHALL take 1 cycle: DIVU returns all ones; REMU returns ALU_in_X.
REQ-021 ALU_out_S, ZR and NG SHALL be registered. They SHALL be stable while out_valid && !out_ready (backpressure hold).
REQ-022 Inputs SHALL be ignored while in_ready=0; operand changes during BUSY SHALL NOT affect the result.
REQ-023 Back-to-back single-cycle ops with out_ready held high SHALL sustain one result per cycle.

Reset
REQ-024 While reset=1 at a clock edge:
- state SHALL become IDLE and out_valid=0.
- ALU_out_S SHALL become 0, ZR=0 and NG=0.
- the iteration counter and accumulators SHALL clear.
REQ-025 Reset during BUSY or DONE SHALL abort the operation; no out_valid SHALL follow for it.
REQ-026 in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification (WIDTH=32)
REQ-027 ADD 0x7FFFFFFF + 0x00000001 -> 0x80000000, NG=1, ZR=0; out_valid exactly 1 cycle after accept.
REQ-028 SUB 5 - 5 -> 0, ZR=1. SLT 0xFFFFFFFF, 1 -> 1. SLTU 0xFFFFFFFF, 1 -> 0. SRA 0x80000000 by 0x24 (shift 4) -> 0xF8000000.
REQ-029 MUL 0x00010000 * 0x00010000 -> 0. MULHU with the same operands -> 0x00000001. out_valid exactly 33 cycles after accept; operands toggled during BUSY do not change the result.
REQ-030 DIVU 100/7 -> 14 and REMU 100/7 -> 2, each at 33 cycles. DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, each at 1 cycle.
REQ-031 out_ready held low for 5 cycles after an ADD result -> ALU_out_S, ZR, NG and out_valid held constant, in_ready=0. Then out_ready=1 with a new in_valid in the same cycle -> the new request is accepted in that cycle.
REQ-032 reset pulsed 10 cycles into a MUL -> next cycle out_valid=0, in_ready=1, ALU_out_S=0. No stale result appears afterwards.
